// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end that shares one combinational ALU, one operation in flight at a time
// Ports:
//   i_clk, i_rst_n                 clock, synchronous active-low reset
//   i_reqN_valid / o_reqN_ready    per-requester handshake (N=0,1)
//   i_reqN_op, i_reqN_a/b/c        opcode and operands 1/2/3 (operand 3 feeds ADD only)
//   o_alu_operand_1/2/3, o_alu_operation, i_alu_result   shared ALU port, driven only in EXEC
//   o_rsp_valid / i_rsp_ready      response handshake
//   o_rsp_result, o_rsp_id, o_rsp_err   registered result, issuing requester, illegal-opcode flag
module alu_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req0_valid,
  output logic        o_req0_ready,
  input  logic [3:0]  i_req0_op,
  input  logic [31:0] i_req0_a,
  input  logic [31:0] i_req0_b,
  input  logic [31:0] i_req0_c,
  input  logic        i_req1_valid,
  output logic        o_req1_ready,
  input  logic [3:0]  i_req1_op,
  input  logic [31:0] i_req1_a,
  input  logic [31:0] i_req1_b,
  input  logic [31:0] i_req1_c,
  output logic [31:0] o_alu_operand_1,
  output logic [31:0] o_alu_operand_2,
  output logic [31:0] o_alu_operand_3,
  output logic [3:0]  o_alu_operation,
  input  logic [31:0] i_alu_result,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_result,
  output logic        o_rsp_id,
  output logic        o_rsp_err
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic        id_q, id_d, err_q, err_d;
  logic [31:0] res_q, res_d;
  logic        idle, exec, gnt0, gnt1, acc;
  logic [3:0]  sel_op;
  always_comb begin
    idle = state_q == IDLE && i_rst_n;
    exec = state_q == EXEC;
    // requester 0 loses a tie only under round-robin with the pointer at 1
    gnt0 = idle && i_req0_valid && (!i_req1_valid || !RR_EN || !ptr_q);
    gnt1 = idle && i_req1_valid && !gnt0;
    acc = gnt0 || gnt1;
    sel_op = gnt1 ? i_req1_op : i_req0_op;
    state_d = state_q == IDLE ? (acc ? EXEC : IDLE) :
              state_q == EXEC ? RESP :
              (i_rsp_ready ? IDLE : RESP);
    ptr_d = (RR_EN && acc) ? !gnt1 : ptr_q;
    op_d = acc ? sel_op : op_q;
    a_d = acc ? (gnt1 ? i_req1_a : i_req0_a) : a_q;
    b_d = acc ? (gnt1 ? i_req1_b : i_req0_b) : b_q;
    c_d = acc ? (gnt1 ? i_req1_c : i_req0_c) : c_q;
    id_d = acc ? gnt1 : id_q;
    err_d = acc ? (sel_op == 4'h0 || sel_op > 4'hA) : err_q;
    res_d = exec ? (err_q ? 32'h0 : i_alu_result) : res_q;
    o_req0_ready = gnt0;
    o_req1_ready = gnt1;
    o_alu_operation = (exec && !err_q) ? op_q : 4'h0;
    o_alu_operand_1 = exec ? a_q : 32'h0;
    o_alu_operand_2 = exec ? b_q : 32'h0;
    o_alu_operand_3 = exec ? c_q : 32'h0;
    o_rsp_valid = state_q == RESP;
    o_rsp_result = res_q;
    o_rsp_id = id_q;
    o_rsp_err = err_q;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      ptr_q <= 1'b0;
      op_q <= 4'h0;
      a_q <= 32'h0;
      b_q <= 32'h0;
      c_q <= 32'h0;
      id_q <= 1'b0;
      err_q <= 1'b0;
      res_q <= 32'h0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      id_q <= id_d;
      err_q <= err_d;
      res_q <= res_d;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of alu_arbiter in round-robin and fixed-priority builds
module tb_alu_arbiter;
  logic clk = 1'b0, rst_n = 1'b0, rsp_ready = 1'b0;
  logic v0 = 1'b0, v1 = 1'b0;
  logic [3:0] op0 = 4'h0, op1 = 4'h0;
  logic [31:0] a0 = 0, b0 = 0, c0 = 0, a1 = 0, b1 = 0, c1 = 0;
  logic r_rdy0, r_rdy1, r_vld, r_id, r_err, f_rdy0, f_rdy1, f_vld, f_id, f_err;
  logic [3:0] r_op, f_op;
  logic [31:0] r_o1, r_o2, r_o3, r_alu, r_res, f_o1, f_o2, f_o3, f_alu, f_res;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, b, c);
    case (op)
      4'h1: return a + b + c;
      4'h2: return a - b;
      4'h3: return {31'b0, $signed(a) < $signed(b)};
      4'h4: return {31'b0, a < b};
      4'h5: return a | b;
      4'h6: return a ^ b;
      4'h7: return a & b;
      4'h8: return a << b[4:0];
      4'h9: return a >> b[4:0];
      4'hA: return $signed(a) >>> b[4:0];
      default: return 32'hDEADBEEF;
    endcase
  endfunction
  assign r_alu = alu_f(r_op, r_o1, r_o2, r_o3);
  assign f_alu = alu_f(f_op, f_o1, f_o2, f_o3);
  alu_arbiter #(.RR_EN(1'b1)) dut_rr (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_valid(v0), .o_req0_ready(r_rdy0), .i_req0_op(op0), .i_req0_a(a0), .i_req0_b(b0), .i_req0_c(c0),
    .i_req1_valid(v1), .o_req1_ready(r_rdy1), .i_req1_op(op1), .i_req1_a(a1), .i_req1_b(b1), .i_req1_c(c1),
    .o_alu_operand_1(r_o1), .o_alu_operand_2(r_o2), .o_alu_operand_3(r_o3), .o_alu_operation(r_op),
    .i_alu_result(r_alu), .o_rsp_valid(r_vld), .i_rsp_ready(rsp_ready),
    .o_rsp_result(r_res), .o_rsp_id(r_id), .o_rsp_err(r_err));
  alu_arbiter #(.RR_EN(1'b0)) dut_fp (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_valid(v0), .o_req0_ready(f_rdy0), .i_req0_op(op0), .i_req0_a(a0), .i_req0_b(b0), .i_req0_c(c0),
    .i_req1_valid(v1), .o_req1_ready(f_rdy1), .i_req1_op(op1), .i_req1_a(a1), .i_req1_b(b1), .i_req1_c(c1),
    .o_alu_operand_1(f_o1), .o_alu_operand_2(f_o2), .o_alu_operand_3(f_o3), .o_alu_operation(f_op),
    .i_alu_result(f_alu), .o_rsp_valid(f_vld), .i_rsp_ready(rsp_ready),
    .o_rsp_result(f_res), .o_rsp_id(f_id), .o_rsp_err(f_err));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  initial begin
    v0 = 1'b1;
    #1 chk("rst_rdy0", r_rdy0, 0);
    cyc;
    #1;
    chk("rst_rdy0_hold", r_rdy0, 0);
    chk("rst_vld", r_vld, 0);
    chk("rst_res", r_res, 0);
    chk("rst_op", r_op, 0);
    v0 = 1'b0;
    rst_n = 1'b1;
    v0 = 1'b1; op0 = 4'h1; a0 = 5; b0 = 7; c0 = 1; rsp_ready = 1'b1;
    #1 chk("add_rdy0", r_rdy0, 1);
    cyc;
    v0 = 1'b0;
    #1;
    chk("add_exec_op", r_op, 1);
    chk("add_exec_o1", r_o1, 5);
    chk("add_exec_o3", r_o3, 1);
    chk("add_exec_vld", r_vld, 0);
    cyc;
    #1;
    chk("add_vld", r_vld, 1);
    chk("add_res", r_res, 13);
    chk("add_id", r_id, 0);
    chk("add_err", r_err, 0);
    chk("add_resp_op", r_op, 0);
    cyc;
    #1 chk("add_idle_vld", r_vld, 0);
    rst_n = 1'b0;
    cyc;
    rst_n = 1'b1;
    v0 = 1'b1; op0 = 4'h1; a0 = 1; b0 = 2; c0 = 0;
    v1 = 1'b1; op1 = 4'h6; a1 = 32'hF0; b1 = 32'hFF; c1 = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr_rdy0_%0d", i), r_rdy0, (i % 2) == 0);
      chk($sformatf("rr_rdy1_%0d", i), r_rdy1, (i % 2) == 1);
      chk($sformatf("fp_rdy0_%0d", i), f_rdy0, 1);
      chk($sformatf("fp_rdy1_%0d", i), f_rdy1, 0);
      cyc;
      cyc;
      #1;
      chk($sformatf("rr_id_%0d", i), r_id, i % 2);
      chk($sformatf("rr_res_%0d", i), r_res, (i % 2) ? 32'h0F : 32'h3);
      chk($sformatf("fp_id_%0d", i), f_id, 0);
      chk($sformatf("fp_res_%0d", i), f_res, 3);
      chk($sformatf("fp_rdy1_resp_%0d", i), f_rdy1, 0);
      cyc;
    end
    v0 = 1'b0; v1 = 1'b0;
    v1 = 1'b1; op1 = 4'hA; a1 = 32'h80000000; b1 = 4; c1 = 0; rsp_ready = 1'b0;
    #1 chk("sra_rdy1", r_rdy1, 1);
    cyc;
    v1 = 1'b0; v0 = 1'b1; op0 = 4'h1; a0 = 9; b0 = 9; c0 = 9;
    #1;
    chk("sra_exec_op", r_op, 4'hA);
    chk("sra_exec_rdy0", r_rdy0, 0);
    cyc;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("sra_vld_%0d", i), r_vld, 1);
      chk($sformatf("sra_res_%0d", i), r_res, 32'hF8000000);
      chk($sformatf("sra_id_%0d", i), r_id, 1);
      chk($sformatf("sra_rdy0_%0d", i), r_rdy0, 0);
      cyc;
    end
    rsp_ready = 1'b1;
    #1;
    chk("sra_hs_vld", r_vld, 1);
    chk("sra_hs_res", r_res, 32'hF8000000);
    chk("sra_hs_rdy0", r_rdy0, 0);
    cyc;
    #1;
    chk("sra_idle_vld", r_vld, 0);
    chk("sra_idle_rdy0", r_rdy0, 1);
    v0 = 1'b0;
    cyc;
    v0 = 1'b1; op0 = 4'hC; a0 = 3; b0 = 4; c0 = 0;
    #1 chk("err_rdy0", r_rdy0, 1);
    cyc;
    v0 = 1'b0;
    #1;
    chk("err_exec_op", r_op, 0);
    chk("err_exec_o1", r_o1, 3);
    cyc;
    #1;
    chk("err_vld", r_vld, 1);
    chk("err_res", r_res, 0);
    chk("err_err", r_err, 1);
    chk("err_id", r_id, 0);
    cyc;
    v0 = 1'b1; op0 = 4'h1; a0 = 2; b0 = 2; c0 = 2;
    #1 chk("abort_rdy0", r_rdy0, 1);
    cyc;
    v0 = 1'b0;
    #1 chk("abort_exec_op", r_op, 1);
    rst_n = 1'b0;
    cyc;
    #1;
    chk("abort_vld", r_vld, 0);
    chk("abort_op", r_op, 0);
    chk("abort_o1", r_o1, 0);
    chk("abort_o3", r_o3, 0);
    chk("abort_res", r_res, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc;
      #1 chk($sformatf("abort_none_%0d", i), r_vld, 0);
    end
    v0 = 1'b1; v1 = 1'b1;
    #1;
    chk("abort_ptr_rdy0", r_rdy0, 1);
    chk("abort_ptr_rdy1", r_rdy1, 0);
    v0 = 1'b0; v1 = 1'b0;
    cyc;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
